// File: rtl/matmul_apb.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_apb
//  Description : APB-mapped signed integer matrix-multiply accelerator.
//                C[NxM] = A[NxK] x B[KxM] (+ previous C when bias is set),
//                computed with one MAC per cycle into one of SP_NTARGETS
//                scratchpad matrices that remain readable over APB.
//  Ports       : clk_i, rst_i             clock / sync active-high reset
//                paddr_i, pwdata_i,       APB request
//                psel_i, penable_i,
//                pwrite_i, pstrb_i
//                pready_o, pslverr_o,     APB response (zero wait states)
//                prdata_o
//                busy_o                   computation in progress
//                done_o                   one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_apb #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int SP_NTARGETS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [BUS_WIDTH-1:0]    pwdata_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [BUS_WIDTH/8-1:0]  pstrb_i,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [BUS_WIDTH-1:0]    prdata_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int c_MAX_DIM  = BUS_WIDTH / DATA_WIDTH;
    localparam int c_DIM_W    = $clog2(c_MAX_DIM);
    localparam int c_SP_DEPTH = SP_NTARGETS * c_MAX_DIM * c_MAX_DIM;
    localparam int c_SP_AW    = $clog2(c_SP_DEPTH);
    localparam int c_IDX_W    = ADDR_WIDTH - 5;
    localparam int c_FLG_W    = c_MAX_DIM * c_MAX_DIM;
    localparam int c_FLG_AW   = $clog2(c_FLG_W);
    localparam int c_NB       = BUS_WIDTH / 8;

    localparam logic [4:0] c_REG_CTRL  = 5'h00;
    localparam logic [4:0] c_REG_A     = 5'h04;
    localparam logic [4:0] c_REG_B     = 5'h08;
    localparam logic [4:0] c_REG_FLAGS = 5'h0C;
    localparam logic [4:0] c_REG_SP    = 5'h10;

    // Storable CTRL bits: bias, write/read target and the three dimensions.
    localparam logic [BUS_WIDTH-1:0] c_CTRL_MASK = BUS_WIDTH'(16'h3F3E);
    localparam logic [1:0]           c_DIM_LAST  = 2'(c_MAX_DIM - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MAC  = 2'd1;
    localparam logic [1:0] c_ST_WB   = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [BUS_WIDTH-1:0] ctrl_q;
    logic [BUS_WIDTH-1:0] a_q  [c_MAX_DIM];
    logic [BUS_WIDTH-1:0] b_q  [c_MAX_DIM];
    logic [BUS_WIDTH-1:0] sp_q [c_SP_DEPTH];
    logic [c_FLG_W-1:0]   flags_q;
    logic [c_DIM_W-1:0]   i_q, j_q, k_q;
    logic [BUS_WIDTH-1:0] acc_q;
    logic                 ovf_q;

    function automatic logic [BUS_WIDTH-1:0] merge_bytes(
        input logic [BUS_WIDTH-1:0] old_v,
        input logic [BUS_WIDTH-1:0] new_v,
        input logic [c_NB-1:0]      strb
    );
        logic [BUS_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < c_NB; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Dimension fields larger than the array size are clamped so the
    // datapath never indexes outside the operand storage.
    function automatic logic [c_DIM_W-1:0] clamp_dim(input logic [1:0] f);
        return (f > c_DIM_LAST) ? c_DIM_W'(c_DIM_LAST) : c_DIM_W'(f);
    endfunction

    // ---------------- APB decode ----------------
    logic                 w_access, w_mapped, w_err, w_wr_ok, w_start, w_start_bad;
    logic [4:0]           w_region;
    logic [c_IDX_W-1:0]   w_idx;
    logic [BUS_WIDTH-1:0] w_ctrl_new;

    assign w_access    = psel_i & penable_i;
    assign w_region    = paddr_i[4:0];
    assign w_idx       = paddr_i[ADDR_WIDTH-1:5];
    assign w_ctrl_new  = merge_bytes(ctrl_q, pwdata_i, pstrb_i);
    assign w_start_bad = w_ctrl_new[0] && ({1'b0, w_ctrl_new[3:2]} >= 3'(SP_NTARGETS));

    always_comb begin
        w_mapped = 1'b0;
        case (w_region)
            c_REG_CTRL, c_REG_FLAGS: w_mapped = (w_idx == '0);
            c_REG_A, c_REG_B:        w_mapped = (w_idx < c_IDX_W'(c_MAX_DIM));
            c_REG_SP:                w_mapped = (w_idx < c_IDX_W'(c_SP_DEPTH));
            default:                 w_mapped = 1'b0;
        endcase
    end

    assign w_err = !w_mapped ||
                   (pwrite_i && (busy_o || w_region == c_REG_FLAGS || w_region == c_REG_SP ||
                                 (w_region == c_REG_CTRL && w_start_bad)));
    assign w_wr_ok   = w_access && pwrite_i && !w_err;
    assign w_start   = w_wr_ok && (w_region == c_REG_CTRL) && w_ctrl_new[0];
    assign pready_o  = w_access;
    assign pslverr_o = w_access && w_err;

    always_comb begin
        prdata_o = '0;
        if (w_access && !pwrite_i && !w_err) begin
            case (w_region)
                c_REG_CTRL:  prdata_o = ctrl_q;
                c_REG_A:     prdata_o = a_q[w_idx[c_DIM_W-1:0]];
                c_REG_B:     prdata_o = b_q[w_idx[c_DIM_W-1:0]];
                c_REG_FLAGS: prdata_o[c_FLG_W-1:0] = flags_q;
                c_REG_SP:    prdata_o = sp_q[w_idx[c_SP_AW-1:0]];
                default:     prdata_o = '0;
            endcase
        end
    end

    // ---------------- MAC datapath ----------------
    logic [c_DIM_W-1:0]          w_n_last, w_k_last, w_m_last;
    logic                        w_last_elem;
    logic signed [DATA_WIDTH-1:0]   w_a_elem, w_b_elem;
    logic signed [2*DATA_WIDTH-1:0] w_prod_n;
    logic signed [BUS_WIDTH-1:0] w_prod;
    logic [BUS_WIDTH-1:0]        w_seed, w_base, w_sum;
    logic [c_SP_AW-1:0]          w_sp_idx;
    logic [c_FLG_AW-1:0]         w_flag_idx;
    logic                        w_ovf_step;

    assign w_n_last    = clamp_dim(ctrl_q[9:8]);
    assign w_k_last    = clamp_dim(ctrl_q[11:10]);
    assign w_m_last    = clamp_dim(ctrl_q[13:12]);
    assign w_last_elem = (i_q == w_n_last) && (j_q == w_m_last);

    assign w_a_elem = a_q[i_q][int'(k_q)*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_elem = b_q[k_q][int'(j_q)*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod_n = w_a_elem * w_b_elem;
    assign w_prod   = BUS_WIDTH'(w_prod_n);

    assign w_sp_idx   = c_SP_AW'(int'(ctrl_q[3:2])*c_MAX_DIM*c_MAX_DIM +
                                 int'(i_q)*c_MAX_DIM + int'(j_q));
    assign w_flag_idx = c_FLG_AW'(int'(i_q)*c_MAX_DIM + int'(j_q));
    assign w_seed     = ctrl_q[1] ? sp_q[w_sp_idx] : '0;
    // First MAC of an element starts from the seed rather than the stale accumulator.
    assign w_base     = (k_q == '0) ? w_seed : acc_q;
    assign w_sum      = w_base + w_prod;
    // Signed overflow: both addends share a sign that the result does not.
    assign w_ovf_step = (w_base[BUS_WIDTH-1] == w_prod[BUS_WIDTH-1]) &&
                        (w_sum[BUS_WIDTH-1] != w_base[BUS_WIDTH-1]);

    assign busy_o = (state_q == c_ST_MAC) || (state_q == c_ST_WB);
    assign done_o = (state_q == c_ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE, c_ST_DONE: state_d = w_start ? c_ST_MAC : c_ST_IDLE;
            c_ST_MAC:             if (k_q == w_k_last) state_d = c_ST_WB;
            c_ST_WB:              state_d = w_last_elem ? c_ST_DONE : c_ST_MAC;
            default:              state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= c_ST_IDLE;
            ctrl_q  <= '0;
            flags_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            for (int n = 0; n < c_MAX_DIM; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
            end
            for (int n = 0; n < c_SP_DEPTH; n++) sp_q[n] <= '0;
        end else begin
            state_q <= state_d;
            if (w_wr_ok) begin
                case (w_region)
                    c_REG_CTRL: ctrl_q <= w_ctrl_new & c_CTRL_MASK;
                    c_REG_A:    a_q[w_idx[c_DIM_W-1:0]] <=
                                    merge_bytes(a_q[w_idx[c_DIM_W-1:0]], pwdata_i, pstrb_i);
                    c_REG_B:    b_q[w_idx[c_DIM_W-1:0]] <=
                                    merge_bytes(b_q[w_idx[c_DIM_W-1:0]], pwdata_i, pstrb_i);
                    default:    ;
                endcase
            end
            case (state_q)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_start) begin
                        flags_q <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                    end
                end
                c_ST_MAC: begin
                    acc_q <= w_sum;
                    ovf_q <= ((k_q == '0) ? 1'b0 : ovf_q) | w_ovf_step;
                    if (k_q != w_k_last) k_q <= k_q + 1'b1;
                end
                c_ST_WB: begin
                    sp_q[w_sp_idx] <= acc_q;
                    if (ovf_q) flags_q[w_flag_idx] <= 1'b1;
                    k_q <= '0;
                    if (j_q == w_m_last) begin
                        j_q <= '0;
                        if (i_q != w_n_last) i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_apb
//  Description : Directed self-checking bench for matmul_apb. One instance
//                uses the default 32-bit bus with four targets, a second uses
//                a 16-bit bus with two targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_apb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwrite, penable;
    logic [1:0]  psel;

    logic        pready0, pslverr0, busy0, done0;
    logic [31:0] prdata0;
    logic        pready1, pslverr1, busy1, done1;
    logic [15:0] prdata1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_apb #(.DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(16), .SP_NTARGETS(4)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .pwdata_i(pwdata), .paddr_i(paddr), .psel_i(psel[0]),
        .penable_i(penable), .pwrite_i(pwrite), .pstrb_i(pstrb), .pready_o(pready0),
        .pslverr_o(pslverr0), .prdata_o(prdata0), .busy_o(busy0), .done_o(done0));

    matmul_apb #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(16), .SP_NTARGETS(2)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .pwdata_i(pwdata[15:0]), .paddr_i(paddr), .psel_i(psel[1]),
        .penable_i(penable), .pwrite_i(pwrite), .pstrb_i(pstrb[1:0]), .pready_o(pready1),
        .pslverr_o(pslverr1), .prdata_o(prdata1), .busy_o(busy1), .done_o(done1));

    typedef struct {
        int          u;
        logic [15:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp;
        logic        exp_err;
        string       nm;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic bsy(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction

    function automatic logic dn(input int u);
        return (u == 0) ? done0 : done1;
    endfunction

    function automatic void add(input int u, input logic [15:0] a, input logic we,
                                input logic [31:0] wd, input logic [31:0] exp,
                                input logic ee, input string nm);
        vec_t v;
        v.u = u; v.addr = a; v.we = we; v.wd = wd; v.st = 4'hF;
        v.exp = exp; v.exp_err = ee; v.nm = nm;
        vq.push_back(v);
    endfunction

    task automatic apb_xfer(input int u, input logic [15:0] addr, input logic we,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd, output logic er);
        @(negedge clk);
        psel    = (u == 0) ? 2'b01 : 2'b10;
        paddr   = addr;
        pwrite  = we;
        pwdata  = wd;
        pstrb   = st;
        penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("pready", 32'((u == 0) ? pready0 : pready1), 32'd1);
        rd = (u == 0) ? prdata0 : {16'h0, prdata1};
        er = (u == 0) ? pslverr0 : pslverr1;
        @(negedge clk);
        psel    = 2'b00;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic run_vecs();
        logic [31:0] rd;
        logic        er;
        foreach (vq[n]) begin
            apb_xfer(vq[n].u, vq[n].addr, vq[n].we, vq[n].wd, vq[n].st, rd, er);
            check({vq[n].nm, " err"}, 32'(er), 32'(vq[n].exp_err));
            if (!vq[n].we && !vq[n].exp_err) check({vq[n].nm, " data"}, rd, vq[n].exp);
        end
        vq.delete();
    endtask

    // Called at the negedge right after the start write committed.
    task automatic wait_done(input int u, input int exp_busy, input string nm);
        int busy_cnt = 0;
        int early    = 0;
        while (bsy(u) && busy_cnt < 200) begin
            busy_cnt++;
            if (dn(u)) early++;
            @(negedge clk);
        end
        check({nm, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({nm, " done while busy"}, 32'(early), 32'd0);
        check({nm, " done pulse"}, 32'(dn(u)), 32'd1);
        @(negedge clk);
        check({nm, " done cleared"}, 32'(dn(u)), 32'd0);
    endtask

    function automatic logic [15:0] ra(input int region, input int idx);
        return 16'(idx * 32 + region);
    endfunction

    initial begin
        logic [31:0] rd;
        logic        er;
        int          g;
        int          dcnt;

        rst = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- reset state and address map ----
        check("reset busy0", 32'(busy0), 32'd0);
        check("reset done0", 32'(done0), 32'd0);
        check("reset busy1", 32'(busy1), 32'd0);
        add(0, 16'h0000, 0, 0, 32'h0, 0, "rst CTRL");
        add(0, 16'h000C, 0, 0, 32'h0, 0, "rst FLAGS");
        add(0, 16'h0010, 0, 0, 32'h0, 0, "rst SP0");
        add(1, 16'h0010, 0, 0, 32'h0, 0, "rst SP0 b16");
        add(0, 16'h0014, 0, 0, 32'h0, 1, "rd unmapped");
        add(0, 16'h0020, 0, 0, 32'h0, 1, "rd CTRL idx1");
        add(0, ra(4, 4), 0, 0, 32'h0, 1, "rd A idx4");
        add(0, ra(4, 3), 0, 0, 32'h0, 0, "rd A idx3");
        add(1, ra(4, 2), 0, 0, 32'h0, 1, "rd A idx2 b16");
        add(1, ra(16, 7), 0, 0, 32'h0, 0, "rd SP idx7 b16");
        add(1, ra(16, 8), 0, 0, 32'h0, 1, "rd SP idx8 b16");
        run_vecs();

        // ---- byte strobes ----
        apb_xfer(0, ra(4, 2), 1, 32'hAABBCCDD, 4'b0101, rd, er);
        check("strb wr err", 32'(er), 32'd0);
        add(0, ra(4, 2), 0, 0, 32'h00BB00DD, 0, "strb A2");
        run_vecs();

        // ---- 1x1x1: -1 * 127 ----
        add(0, ra(4, 0), 1, 32'h000000FF, 0, 0, "wr A0 m1");
        add(0, ra(8, 0), 1, 32'h0000007F, 0, 0, "wr B0 127");
        add(0, 16'h0000, 1, 32'h00000001, 0, 0, "start 1x1");
        run_vecs();
        wait_done(0, 2, "1x1");
        add(0, ra(16, 0), 0, 0, 32'hFFFFFF81, 0, "1x1 SP0");
        add(0, ra(16, 1), 0, 0, 32'h0, 0, "1x1 SP1 untouched");
        add(0, 16'h000C, 0, 0, 32'h0, 0, "1x1 FLAGS");
        add(0, 16'h0000, 0, 0, 32'h0, 0, "1x1 CTRL start clr");
        run_vecs();

        // ---- 2x2x2: A x I ----
        add(0, ra(4, 0), 1, 32'h00000201, 0, 0, "wr A0");
        add(0, ra(4, 1), 1, 32'h00000403, 0, 0, "wr A1");
        add(0, ra(8, 0), 1, 32'h00000001, 0, 0, "wr B0");
        add(0, ra(8, 1), 1, 32'h00000100, 0, 0, "wr B1");
        add(0, 16'h0000, 1, 32'h00001501, 0, 0, "start 2x2");
        run_vecs();
        wait_done(0, 12, "2x2");
        add(0, ra(16, 0), 0, 0, 32'd1, 0, "2x2 C00");
        add(0, ra(16, 1), 0, 0, 32'd2, 0, "2x2 C01");
        add(0, ra(16, 4), 0, 0, 32'd3, 0, "2x2 C10");
        add(0, ra(16, 5), 0, 0, 32'd4, 0, "2x2 C11");
        add(0, ra(16, 2), 0, 0, 32'd0, 0, "2x2 C02 untouched");
        add(0, 16'h0000, 0, 0, 32'h00001500, 0, "2x2 CTRL");
        run_vecs();

        // ---- same with bias ----
        add(0, 16'h0000, 1, 32'h00001503, 0, 0, "start bias");
        run_vecs();
        wait_done(0, 12, "bias");
        add(0, ra(16, 0), 0, 0, 32'd2, 0, "bias C00");
        add(0, ra(16, 1), 0, 0, 32'd4, 0, "bias C01");
        add(0, ra(16, 4), 0, 0, 32'd6, 0, "bias C10");
        add(0, ra(16, 5), 0, 0, 32'd8, 0, "bias C11");
        add(0, ra(16, 16), 0, 0, 32'd0, 0, "bias SP1");
        add(0, ra(16, 32), 0, 0, 32'd0, 0, "bias SP2");
        add(0, ra(16, 48), 0, 0, 32'd0, 0, "bias SP3");
        add(0, 16'h000C, 0, 0, 32'd0, 0, "bias FLAGS");
        run_vecs();

        // ---- 16-bit bus overflow ----
        add(1, ra(4, 0), 1, 32'h00008080, 0, 0, "b16 wr A0");
        add(1, ra(8, 0), 1, 32'h00000080, 0, 0, "b16 wr B0");
        add(1, ra(8, 1), 1, 32'h00000080, 0, 0, "b16 wr B1");
        add(1, 16'h0000, 1, 32'h00000401, 0, 0, "b16 start");
        run_vecs();
        wait_done(1, 3, "b16");
        add(1, ra(16, 0), 0, 0, 32'h00008000, 0, "b16 SP0");
        add(1, 16'h000C, 0, 0, 32'h00000001, 0, "b16 FLAGS");
        add(1, 16'h0000, 1, 32'h0000000D, 0, 1, "b16 start wt3");
        add(1, 16'h0000, 0, 0, 32'h00000400, 0, "b16 CTRL kept");
        add(1, 16'h000C, 1, 32'h0, 0, 1, "b16 wr FLAGS");
        add(1, 16'h0010, 1, 32'h0, 0, 1, "b16 wr SP");
        add(0, 16'h0014, 1, 32'h0, 0, 1, "wr unmapped");
        run_vecs();
        check("b16 wt3 no busy", 32'(busy1), 32'd0);

        // ---- writes while busy ----
        apb_xfer(0, 16'h0000, 1, 32'h00001501, 4'hF, rd, er);
        check("busy start err", 32'(er), 32'd0);
        apb_xfer(0, ra(4, 0), 1, 32'h00007F7F, 4'hF, rd, er);
        check("busy wr A err", 32'(er), 32'd1);
        apb_xfer(0, 16'h0000, 1, 32'h00000001, 4'hF, rd, er);
        check("busy wr CTRL err", 32'(er), 32'd1);
        apb_xfer(0, ra(16, 5), 0, 32'h0, 4'h0, rd, er);
        check("busy rd err", 32'(er), 32'd0);
        g = 0;
        while (busy0 && g < 100) begin g++; @(negedge clk); end
        check("busy drained", 32'(busy0), 32'd0);
        add(0, ra(4, 0), 0, 0, 32'h00000201, 0, "busy A0 kept");
        add(0, ra(16, 0), 0, 0, 32'd1, 0, "busy C00");
        add(0, ra(16, 5), 0, 0, 32'd4, 0, "busy C11");
        run_vecs();

        // ---- reset mid-computation ----
        apb_xfer(0, 16'h0000, 1, 32'h00001501, 4'hF, rd, er);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy0), 32'd0);
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done0) dcnt++;
            @(negedge clk);
        end
        check("abort no done", 32'(dcnt), 32'd0);
        add(0, ra(16, 0), 0, 0, 32'd0, 0, "abort SP0");
        add(0, 16'h0000, 0, 0, 32'd0, 0, "abort CTRL");
        add(0, ra(4, 0), 0, 0, 32'd0, 0, "abort A0");
        run_vecs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
